ramp_gen_param: RTL
===================

// Module: ramp_gen_param
// PURPOSE
//  Parametrised ramp/pattern counter for the pattern-generator datapath.
//  Accumulates a selectable step on each rising edge of a delta strobe.
//  Three modes: wrap (sawtooth), saturate (one-shot ramp), triangle (up/down).
//  Feeds the pattern DAC/pixel path; status flags go to the pattern sequencer.
// PARAMETERS
//  W        12    output/accumulator width (bits), 4..24
//  MAX_VAL  4095  upper bound of out, 1 <= MAX_VAL <= 2^W-1
//  STEP0    0     step for Y=2'b00
//  STEP1    1     step for Y=2'b01
//  STEP2    16    step for Y=2'b10
//  STEP3    1290  step for Y=2'b11; every STEPn <= MAX_VAL
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   reset, asynchronous, active low
//  ramp_enb    in   1   active high; low = synchronous clear and hold
//  delta       in   1   step strobe, level input; stepping on its rising edge
//  Y           in   2   step select, indexes STEP0..STEP3
//  mode        in   2   00 WRAP, 01 SAT, 10 TRI, 11 HOLD (no stepping)
//  out         out  W   current ramp value
//  dir         out  1   1 = counting down (TRI only), else 0
//  wrap_pulse  out  1   1-cycle pulse on wrap (WRAP) or turnaround (TRI)
//  done        out  1   sticky; set when SAT reaches MAX_VAL
// BEHAVIOUR
//  - rst_n=0: out=0, dir=0, wrap_pulse=0, done=0, delta edge history=0, async.
//  - ramp_enb=0 (sync): out=0, dir=0, done=0, wrap_pulse=0, history<=delta.
//  - Edge: rise = delta & ~delta_q; delta_q registered every cycle.
//    out updates on the clock edge where rise=1 (1 clk latency after delta rises).
//    Holding delta high = one step only; no step without rise.
//  - Y and mode are sampled at the step edge; changing them between steps is legal.
//  - Sum s = out + STEP[Y], computed in W+1 bits (no silent overflow).
//  - WRAP: s > MAX_VAL -> out = s-(MAX_VAL+1), wrap_pulse=1; else out=s. dir=0.
//  - SAT: s >= MAX_VAL -> out=MAX_VAL, done=1; done stays until ramp_enb=0 or
//    reset; further steps hold MAX_VAL. dir=0.
//  - TRI up (dir=0): s >= MAX_VAL -> out=MAX_VAL, dir=1, wrap_pulse=1.
//    TRI down (dir=1): out <= STEP[Y] -> out=0, dir=0, wrap_pulse=1;
//    else out=out-STEP[Y].
//  - HOLD or STEP=0: out unchanged, no pulses, dir unchanged.
//  - Mode switch TRI->WRAP/SAT while dir=1: dir cleared on next step, counts up.
//  - wrap_pulse is high only in the cycle after the qualifying step, else 0.
//  - Reset mid-ramp: immediate return to reset values; first rise after release
//    steps from 0.
// STRUCTURE
//  - ramp_pkg: mode localparams MODE_WRAP/SAT/TRI/HOLD, 2-bit mode type.
//  - Sub-module rise_detect (clk, rst_n, clr, d -> rise): delta_q register + AND.
//  - Top: step-select mux, W+1 adder/subtractor, mode case, output registers.
// TESTING
//  1 reset: rst_n=0 mid-count (out=100) -> out=0, dir=0, done=0 asynchronously.
//  2 WRAP Y=11, 4 rises from 0 -> out 1290,2580,3870,1064; wrap_pulse on 4th.
//  3 SAT Y=11, 4 rises -> 1290,2580,3870,4095, done=1; 5th rise keeps 4095.
//  4 TRI Y=10 from 4080: rise -> 4095, dir=1, pulse; rise -> 4079; then from
//    out=8 rise -> 0, dir=0, pulse.
//  5 delta held high 10 cycles, Y=01 -> out increments by exactly 1.
//  6 ramp_enb=0 with done=1, out=4095 -> next clk out=0, done=0; mode=11 rises
//    -> out stays 0.

Source files
------------

// File: rtl/ramp_gen_param_pkg.sv
// Shared types and mode encodings for the ramp/pattern generator.
package ramp_gen_param_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_WRAP = 2'b00;
  localparam mode_t MODE_SAT  = 2'b01;
  localparam mode_t MODE_TRI  = 2'b10;
  localparam mode_t MODE_HOLD = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/ramp_gen_param_if.sv
// Control/status bundle between the pattern sequencer and the ramp generator.
interface ramp_gen_param_if
  import ramp_gen_param_pkg::*;
#(
  parameter int W = 12
);
  logic         ramp_enb;
  logic         delta;
  logic [1:0]   Y;
  mode_t        mode;
  logic [W-1:0] out;
  logic         dir;
  logic         wrap_pulse;
  logic         done;

  modport master (
    output ramp_enb, delta, Y, mode,
    input  out, dir, wrap_pulse, done
  );

  modport slave (
    input  ramp_enb, delta, Y, mode,
    output out, dir, wrap_pulse, done
  );
endinterface

// File: rtl/ramp_gen_param_rise_detect.sv
// Rising-edge detector for the delta strobe. History keeps tracking d while
// clr is high so that a level already high at enable does not count as an edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic rise
);
  logic d_q;

  // one-cycle history of d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q & ~clr;
endmodule

// File: rtl/ramp_gen_param.sv
// Ramp/pattern counter: steps out by STEP[Y] on each rising delta edge,
// in wrap, saturate or triangle mode.
//
//  state    | meaning
//  DIR_UP   | counting up (all modes; only state outside TRI)
//  DIR_DOWN | TRI descending after reaching MAX_VAL
module ramp_gen_param
  import ramp_gen_param_pkg::*;
#(
  parameter int unsigned W       = 12,
  parameter int unsigned MAX_VAL = 4095,
  parameter int unsigned STEP0   = 0,
  parameter int unsigned STEP1   = 1,
  parameter int unsigned STEP2   = 16,
  parameter int unsigned STEP3   = 1290
) (
  input logic             clk,
  input logic             rst_n,
  ramp_gen_param_if.slave bus
);
  localparam logic [W:0] MAX_EXT = (W+1)'(MAX_VAL);
  localparam logic [W:0] ONE_EXT = (W+1)'(1);

  logic         rise;
  logic [W:0]   step_ext;
  logic [W:0]   out_ext;
  logic [W:0]   sum;

  logic [W-1:0] out_q, out_d;
  dir_e         dir_q, dir_d;
  logic         done_q, done_d;
  logic         pulse_q, pulse_d;

  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~bus.ramp_enb),
    .d     (bus.delta),
    .rise  (rise)
  );

  // step select and one-bit-wider sum so overflow past 2^W is visible
  always_comb begin
    step_ext = '0;
    case (bus.Y)
      2'b00:   step_ext = (W+1)'(STEP0);
      2'b01:   step_ext = (W+1)'(STEP1);
      2'b10:   step_ext = (W+1)'(STEP2);
      default: step_ext = (W+1)'(STEP3);
    endcase
    out_ext = {1'b0, out_q};
    sum     = out_ext + step_ext;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
    end
  end

  // next-state: a zero step or HOLD leaves everything, including dir, untouched
  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    done_d  = done_q;
    pulse_d = 1'b0;
    if (!bus.ramp_enb) begin
      out_d  = '0;
      dir_d  = DIR_UP;
      done_d = 1'b0;
    end else if (rise && (bus.mode != MODE_HOLD) && (step_ext != '0)) begin
      case (bus.mode)
        MODE_WRAP: begin
          dir_d = DIR_UP;
          if (sum > MAX_EXT) begin
            out_d   = W'(sum - MAX_EXT - ONE_EXT);
            pulse_d = 1'b1;
          end else begin
            out_d = W'(sum);
          end
        end
        MODE_SAT: begin
          dir_d = DIR_UP;
          if (sum >= MAX_EXT) begin
            out_d  = W'(MAX_EXT);
            done_d = 1'b1;
          end else begin
            out_d = W'(sum);
          end
        end
        MODE_TRI: begin
          if (dir_q == DIR_UP) begin
            if (sum >= MAX_EXT) begin
              out_d   = W'(MAX_EXT);
              dir_d   = DIR_DOWN;
              pulse_d = 1'b1;
            end else begin
              out_d = W'(sum);
            end
          end else begin
            if (out_ext <= step_ext) begin
              out_d   = '0;
              dir_d   = DIR_UP;
              pulse_d = 1'b1;
            end else begin
              out_d = W'(out_ext - step_ext);
            end
          end
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
  end

  assign bus.out        = out_q;
  assign bus.dir        = (dir_q == DIR_DOWN);
  assign bus.wrap_pulse = pulse_q;
  assign bus.done       = done_q;
endmodule
